// File: rtl/multi_cycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I main control FSM:
// opcode constants, state encoding, datapath select encodings and
// the packed bundle of control outputs.
package multi_cycle_control_unit_pkg;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] OP_ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD           = 7'b0000011;
  localparam logic [6:0] OP_STORE          = 7'b0100011;
  localparam logic [6:0] OP_BRANCH         = 7'b1100011;
  localparam logic [6:0] OP_JAL            = 7'b1101111;
  localparam logic [6:0] OP_JALR           = 7'b1100111;
  localparam logic [6:0] OP_ECALL          = 7'b1110011;

  // Main FSM states
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  // ALU decode mode handed to the ALU control unit
  localparam logic [1:0] ALU_CTRL_ADD    = 2'b00;
  localparam logic [1:0] ALU_CTRL_BRANCH = 2'b01;
  localparam logic [1:0] ALU_CTRL_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_CTRL_OPCODE = 2'b11;

  // ALU operand B select
  localparam logic [1:0] ALUSRCB_B    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

  // Register-file write data select
  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

  // All Moore control outputs decoded from the state
  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl_op;
    logic       is_ecall;
    logic       is_halted;
  } ctrl_t;

  // Opcodes this control unit knows how to execute; anything else is a NOP
  function automatic logic is_known_opcode(input logic [6:0] op);
    logic known;
    known = 1'b0;
    case (op)
      OP_ARITHMETIC, OP_ARITHMETIC_IMM, OP_LOAD, OP_STORE,
      OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/multi_cycle_control_unit_mem_wait_timer.sv
// Memory wait watchdog: counts consecutive cycles spent waiting on
// mem_ready in a memory-access state and flags the cycle on which the
// MEM_TIMEOUT-th wait elapses without a response. MEM_TIMEOUT = 0 disables it.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TIMER_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  // Count value during the last permitted wait cycle
  localparam logic [TIMER_W-1:0] LIMIT = (MEM_TIMEOUT > 0) ? TIMER_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [TIMER_W-1:0] SAT   = '1;
  localparam logic               ENABLE = (MEM_TIMEOUT > 0);

  logic [TIMER_W-1:0] count;

  // Count wait cycles; a response or leaving the access state clears, the top value holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!waiting || mem_ready) begin
      count <= '0;
    end else if (count != SAT) begin
      count <= count + TIMER_W'(1);
    end
  end

  // A response in the final permitted cycle still completes normally
  assign timeout = ENABLE && waiting && !mem_ready && (count >= LIMIT);

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Main control FSM of the multi-cycle RV32I core. Sequences
// IF/ID/EX/MEM/WB/BR, drives all datapath enables and selects, waits on a
// variable-latency unified memory and halts on ecall or memory timeout.
module multi_cycle_control_unit
  import multi_cycle_control_unit_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TIMER_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       bcond,
  input  logic       halt_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl_op,
  output logic       is_ecall,
  output logic       is_halted,
  output logic       mem_error
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  logic   waiting;
  logic   timeout;
  logic   mem_error_q;

  assign waiting = (state == S_IF) || (state == S_MEM);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TIMER_W     (TIMER_W)
  ) u_mem_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // State register; reset abandons any access in flight and restarts at fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IF;
    end else begin
      state <= state_nxt;
    end
  end

  // Sticky memory error, only cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_error_q <= 1'b0;
    end else if (timeout) begin
      mem_error_q <= 1'b1;
    end
  end

  // Next-state and Moore output decode; outputs forced low while in reset
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = mem_ready;
        if (mem_ready) begin
          state_nxt = S_ID;
        end else if (timeout) begin
          state_nxt = S_HALT;
        end
      end
      S_ID: begin
        // ALUOut captures PC+4 for JAL/JALR link and the WB increment
        ctrl.alu_src_b   = ALUSRCB_FOUR;
        ctrl.alu_ctrl_op = ALU_CTRL_ADD;
        ctrl.is_ecall    = (opcode == OP_ECALL);
        if (opcode == OP_ECALL) begin
          state_nxt = halt_req ? S_HALT : S_WB;
        end else if (!is_known_opcode(opcode)) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_EX;
        end
      end
      S_EX: begin
        case (opcode)
          OP_ARITHMETIC: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = ALUSRCB_B;
            ctrl.alu_ctrl_op = ALU_CTRL_RTYPE;
            state_nxt        = S_WB;
          end
          OP_ARITHMETIC_IMM: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = ALUSRCB_IMM;
            ctrl.alu_ctrl_op = ALU_CTRL_OPCODE;
            state_nxt        = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = ALUSRCB_IMM;
            ctrl.alu_ctrl_op = ALU_CTRL_ADD;
            state_nxt        = S_MEM;
          end
          OP_BRANCH: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = ALUSRCB_B;
            ctrl.alu_ctrl_op = ALU_CTRL_BRANCH;
            state_nxt        = bcond ? S_BR : S_WB;
          end
          OP_JAL, OP_JALR: begin
            // Jump target from the ALU this cycle; link value PC+4 already sits in ALUOut
            ctrl.alu_src_a   = (opcode == OP_JALR);
            ctrl.alu_src_b   = ALUSRCB_IMM;
            ctrl.alu_ctrl_op = ALU_CTRL_ADD;
            ctrl.pc_write    = 1'b1;
            ctrl.reg_write   = 1'b1;
            ctrl.mem_to_reg  = MEMTOREG_PC4;
            state_nxt        = S_IF;
          end
          default: begin
            state_nxt = S_WB;
          end
        endcase
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (opcode == OP_LOAD);
        ctrl.mem_write = (opcode == OP_STORE);
        if (mem_ready) begin
          state_nxt = S_WB;
        end else if (timeout) begin
          state_nxt = S_HALT;
        end
      end
      S_BR: begin
        ctrl.alu_src_b   = ALUSRCB_IMM;
        ctrl.alu_ctrl_op = ALU_CTRL_ADD;
        ctrl.pc_write    = 1'b1;
        state_nxt        = S_IF;
      end
      S_WB: begin
        ctrl.alu_src_b   = ALUSRCB_FOUR;
        ctrl.alu_ctrl_op = ALU_CTRL_ADD;
        ctrl.pc_write    = 1'b1;
        ctrl.reg_write   = (opcode == OP_ARITHMETIC) || (opcode == OP_ARITHMETIC_IMM) ||
                           (opcode == OP_LOAD);
        ctrl.mem_to_reg  = (opcode == OP_LOAD) ? MEMTOREG_MDR : MEMTOREG_ALU;
        state_nxt        = S_IF;
      end
      S_HALT: begin
        ctrl.is_halted = 1'b1;
      end
      default: begin
        state_nxt = S_IF;
      end
    endcase
    if (!reset) begin
      ctrl = '0;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign pc_source   = ctrl.pc_source;
  assign i_or_d      = ctrl.i_or_d;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign ir_write    = ctrl.ir_write;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign reg_write   = ctrl.reg_write;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_ctrl_op = ctrl.alu_ctrl_op;
  assign is_ecall    = ctrl.is_ecall;
  assign is_halted   = ctrl.is_halted;
  assign mem_error   = mem_error_q & reset;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-instruction expected output traces
// are built from the instruction class and memory wait counts, then replayed
// cycle by cycle against the DUT.
module tb_multi_cycle_control_unit;

  localparam int TO = 4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl_op;
    logic       is_ecall;
    logic       is_halted;
    logic       mem_error;
  } ov_t;

  typedef struct {
    ov_t  o;
    logic rdy;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = '0;
  logic       bcond = 1'b0;
  logic       halt_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] mem_to_reg;
  logic       reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_ctrl_op;
  logic       is_ecall, is_halted, mem_error;

  ov_t   got;
  step_t q[$];
  int    compared = 0;
  int    mismatched = 0;
  logic  model_err = 1'b0;

  always #5 clk = ~clk;

  multi_cycle_control_unit #(
    .MEM_TIMEOUT (TO),
    .TIMER_W     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .bcond       (bcond),
    .halt_req    (halt_req),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_source   (pc_source),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_ctrl_op (alu_ctrl_op),
    .is_ecall    (is_ecall),
    .is_halted   (is_halted),
    .mem_error   (mem_error)
  );

  assign got = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_ctrl_op, is_ecall, is_halted, mem_error};

  task automatic check(input string tag, input ov_t exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic ov_t blank();
    ov_t o;
    o = '0;
    o.mem_error = model_err;
    return o;
  endfunction

  task automatic push(input ov_t o, input logic rdy);
    step_t s;
    s.o   = o;
    s.rdy = rdy;
    q.push_back(s);
  endtask

  task automatic push_halt(input int n);
    ov_t o;
    for (int i = 0; i < n; i++) begin
      o = blank();
      o.is_halted = 1'b1;
      push(o, 1'($urandom));
    end
  endtask

  // Expected per-cycle trace of one instruction from its class and wait counts
  task automatic plan(input logic [6:0] opc, input int if_w, input int mem_w);
    ov_t o;
    bit  known, do_mem, do_br, do_wb, wb_rw, is_jump;
    int  n;
    // fetch
    n = (if_w < TO) ? if_w : TO;
    for (int i = 0; i < n; i++) begin
      o = blank(); o.mem_read = 1'b1; push(o, 1'b0);
    end
    if (if_w >= TO) begin
      model_err = 1'b1; push_halt(6); return;
    end
    o = blank(); o.mem_read = 1'b1; o.ir_write = 1'b1; push(o, 1'b1);
    // decode
    o = blank(); o.alu_src_b = 2'b01; o.is_ecall = (opc == OP_ECALL); push(o, 1'($urandom));
    if (opc == OP_ECALL && halt_req) begin
      push_halt(20); return;
    end
    known   = (opc == OP_R) || (opc == OP_I) || (opc == OP_LD) || (opc == OP_ST) ||
              (opc == OP_BR) || (opc == OP_JAL) || (opc == OP_JALR);
    is_jump = (opc == OP_JAL) || (opc == OP_JALR);
    do_mem  = (opc == OP_LD) || (opc == OP_ST);
    do_br   = (opc == OP_BR) && bcond;
    do_wb   = !is_jump && !do_br;
    wb_rw   = (opc == OP_R) || (opc == OP_I) || (opc == OP_LD);
    // execute
    if (known) begin
      o = blank();
      o.alu_src_a = 1'b1;
      if (opc == OP_R) o.alu_ctrl_op = 2'b10;
      if (opc == OP_I) begin o.alu_src_b = 2'b10; o.alu_ctrl_op = 2'b11; end
      if (do_mem) o.alu_src_b = 2'b10;
      if (opc == OP_BR) o.alu_ctrl_op = 2'b01;
      if (is_jump) begin
        o.alu_src_a = (opc == OP_JALR); o.alu_src_b = 2'b10;
        o.pc_write = 1'b1; o.reg_write = 1'b1; o.mem_to_reg = 2'b10;
      end
      push(o, 1'($urandom));
    end
    // memory
    if (do_mem) begin
      n = (mem_w < TO) ? mem_w : TO;
      for (int i = 0; i <= n; i++) begin
        if (i == TO) break;
        o = blank(); o.i_or_d = 1'b1;
        o.mem_read = (opc == OP_LD); o.mem_write = (opc == OP_ST);
        push(o, (i == mem_w));
      end
      if (mem_w >= TO) begin
        model_err = 1'b1; push_halt(6); return;
      end
    end
    if (do_br) begin
      o = blank(); o.alu_src_b = 2'b10; o.pc_write = 1'b1; push(o, 1'($urandom));
    end
    if (do_wb) begin
      o = blank(); o.alu_src_b = 2'b01; o.pc_write = 1'b1;
      o.reg_write = wb_rw; o.mem_to_reg = (opc == OP_LD) ? 2'b01 : 2'b00;
      push(o, 1'($urandom));
    end
  endtask

  // Replay up to n queued steps (n < 0: all); entered and left just after a rising edge
  task automatic run_q(input string tag, input int n);
    step_t s;
    int    idx;
    idx = 0;
    while (q.size() > 0 && (n < 0 || idx < n)) begin
      s = q.pop_front();
      mem_ready = s.rdy;
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, idx), s.o);
      @(posedge clk); #1;
      idx++;
    end
    q.delete();
  endtask

  task automatic instr(input string tag, input logic [6:0] opc, input logic bc,
                       input logic hr, input int if_w, input int mem_w);
    opcode   = opc;
    bcond    = bc;
    halt_req = hr;
    plan(opc, if_w, mem_w);
    run_q(tag, -1);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b0;
    mem_ready = 1'b1;
    #1 check({tag, "_async"}, ov_t'(0));
    repeat (2) @(posedge clk);
    #1 check({tag, "_hold"}, ov_t'(0));
    reset = 1'b1;
    model_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [6:0] ops[10];
    logic [6:0] opc;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_ECALL, 7'b0000000, 7'b1111111};

    // reset state, with mem_ready high so any ungated fetch decode would show
    reset = 1'b0;
    mem_ready = 1'b1;
    #2 check("reset_init", ov_t'(0));
    @(posedge clk); #1 check("reset_edge", ov_t'(0));
    @(posedge clk); #1;
    reset = 1'b1;

    // directed instructions
    instr("add",      OP_R,     1'b0, 1'b0, 0, 0);
    instr("lw_wait",  OP_LD,    1'b0, 1'b0, 2, 3);
    instr("beq_tk",   OP_BR,    1'b1, 1'b0, 0, 0);
    instr("beq_nt",   OP_BR,    1'b0, 1'b0, 0, 0);
    instr("jalr",     OP_JALR,  1'b0, 1'b0, 0, 0);
    instr("jal",      OP_JAL,   1'b0, 1'b0, 1, 0);
    instr("sw",       OP_ST,    1'b0, 1'b0, 0, 0);
    instr("ecall_nh", OP_ECALL, 1'b0, 1'b0, 0, 0);
    instr("lw_edge",  OP_LD,    1'b0, 1'b0, TO - 1, TO - 1);

    // randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      opc = ops[$urandom_range(0, 9)];
      instr($sformatf("rnd%0d", k), opc, 1'($urandom), 1'b0,
            $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end

    // ecall halt, held until reset
    instr("ecall_halt", OP_ECALL, 1'b0, 1'b1, 0, 0);
    do_reset("rst_after_halt");

    // fetch watchdog
    instr("wd_if", OP_R, 1'b0, 1'b0, TO + 3, 0);
    do_reset("rst_after_wd_if");
    instr("after_wd", OP_I, 1'b0, 1'b0, 0, 0);

    // memory-stage watchdog on a store
    instr("wd_mem", OP_ST, 1'b0, 1'b0, 0, TO + 2);
    do_reset("rst_after_wd_mem");

    // reset pulse in the middle of a load's memory wait
    opcode = OP_LD; bcond = 1'b0; halt_req = 1'b0;
    plan(OP_LD, 0, TO - 1);
    run_q("lw_pre_rst", 4);
    mem_ready = 1'b0;
    #2 reset = 1'b0;
    #1 check("rst_mid_mem", ov_t'(0));
    @(negedge clk);
    check("rst_mid_mem_hold", ov_t'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    model_err = 1'b0;
    instr("after_mid_rst", OP_LD, 1'b0, 1'b0, 1, 0);
    instr("final_add", OP_R, 1'b0, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control_unit.md
Name: multi_cycle_control_unit

Overview:
Main control FSM for the multi-cycle RV32I datapath. It is the stage directly upstream of the ALU control unit and produces `alu_ctrl_op`, which selects the ALU decode mode. It also sequences IF/ID/EX/MEM/WB, generates all datapath enables and mux selects, and handshakes with a variable-latency unified memory via `mem_ready`. An optional watchdog halts the core if memory never responds.

Parameters:
- MEM_TIMEOUT, 0: maximum cycles to wait for `mem_ready` in IF/MEM; 0 disables the watchdog.
- TIMER_W, 8: width of the wait counter; MEM_TIMEOUT must be less than 2**TIMER_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- opcode  input  7  IR[6:0]; values per shared opcode constants.
- bcond  input  1  branch condition from ALU; valid in EX for BRANCH.
- halt_req  input  1  ecall-halt condition (x17==10), sampled in ID.
- mem_ready  input  1  memory access complete this cycle.
- pc_write  output  1  PC register load enable.
- pc_source  output  1  0 = ALU result, 1 = ALUOut register.
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load enable.
- mem_to_reg  output  2  RF write data: 00 = ALUOut, 01 = MDR, 10 = ALUOut holding PC+4.
- reg_write  output  1  RF write enable.
- alu_src_a  output  1  0 = PC, 1 = A register.
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = immediate.
- alu_ctrl_op  output  2  00 = add, 01 = branch compare, 10 = R-type funct decode, 11 = opcode decode.
- is_ecall  output  1  high in ID when opcode is ECALL.
- is_halted  output  1  core halted.
- mem_error  output  1  sticky; set on watchdog expiry.

Behaviour:
- States: IF, ID, EX, MEM, WB, BR, HALT. Outputs are Moore, decoded from state, plus opcode, bcond and mem_ready where noted.
- While reset is low: state = IF, timer = 0, mem_error = 0, and every output is forced to 0.
- The first rising edge after reset is released is in IF.
- Reset asserted mid-access abandons the access immediately.
- IF:
  - Drives mem_read=1, i_or_d=0.
  - ir_write = mem_ready.
  - mem_ready=1 -> ID; otherwise stay in IF.
- ID:
  - Drives alu_src_a=0, alu_src_b=01, alu_ctrl_op=00, so ALUOut latches PC+4.
  - is_ecall = (opcode==ECALL).
  - ECALL with halt_req=1 -> HALT.
  - ECALL with halt_req=0, or unknown opcode -> WB (NOP).
  - All other opcodes -> EX.
- EX, by opcode:
  - ARITHMETIC: src_a=1, src_b=00, alu_ctrl_op=10 -> WB.
  - ARITHMETIC_IMM: src_a=1, src_b=10, alu_ctrl_op=11 -> WB.
  - LOAD/STORE: src_a=1, src_b=10, alu_ctrl_op=00 -> MEM.
  - BRANCH: src_a=1, src_b=00, alu_ctrl_op=01; bcond=1 -> BR, else -> WB.
  - JAL: src_a=0, src_b=10, alu_ctrl_op=00, pc_write=1, pc_source=0, reg_write=1, mem_to_reg=10 -> IF.
  - JALR: as JAL but src_a=1.
- MEM:
  - Drives i_or_d=1.
  - mem_read=1 for LOAD; mem_write=1 for STORE.
  - Request is held until mem_ready=1, then -> WB.
- BR: src_a=0, src_b=10, alu_ctrl_op=00, pc_write=1, pc_source=0 -> IF.
- WB:
  - Drives src_a=0, src_b=01, alu_ctrl_op=00, pc_write=1, pc_source=0, so PC = PC+4.
  - reg_write=1 only for ARITHMETIC, ARITHMETIC_IMM, LOAD.
  - mem_to_reg = 01 for LOAD, else 00.
  - -> IF.
- HALT: is_halted=1, all other enables 0; exits only via reset.
- Watchdog (MEM_TIMEOUT>0):
  - The timer counts cycles in IF/MEM while mem_ready=0 and clears on state change.
  - When it reaches MEM_TIMEOUT with mem_ready still 0 -> HALT and mem_error=1.
  - mem_ready=1 on the same cycle the timer reaches MEM_TIMEOUT completes the access normally; it is not an error.
  - The timer saturates and never wraps.
- CPI: R/I = 4; LOAD/STORE = 5 with zero-wait memory; JAL/JALR = 3; branch = 4. Each wait cycle adds 1.
- Unused select outputs are 0 in every state.

Decomposition:
- Shared header (alongside opcodes.v):
  - state encodings;
  - ALU_CTRL_ADD/BRANCH/RTYPE/OPCODE;
  - ALUSRCB_B/FOUR/IMM;
  - MEMTOREG_ALU/MDR/PC4.
- One sub-module, mem_wait_timer: counter, saturation, and timeout compare.

Test Plan:
- add x3,x1,x2 (opcode 0110011), mem_ready tied 1 -> states IF,ID,EX,WB; alu_ctrl_op 00,00,10,00; reg_write only in WB; pc_write in WB.
- lw (0000011), mem_ready low 2 cycles in IF and 3 cycles in MEM -> ir_write pulses once; mem_read held steady; mem_to_reg=01 in WB; 10 cycles total.
- beq with bcond=1 -> EX alu_ctrl_op=01, then BR with pc_write=1, src_b=10; with bcond=0 -> WB PC+4 and reg_write=0.
- jalr (1100111) -> 3 cycles; EX asserts pc_write, reg_write, mem_to_reg=10, src_a=1 together.
- ecall (1110011) with halt_req=1 -> is_ecall in ID, then is_halted=1 held for 20 cycles; with halt_req=0 -> WB with no reg_write.
- MEM_TIMEOUT=4, mem_ready stuck 0 in IF -> HALT and mem_error=1 after 4 wait cycles. Reset pulse mid-MEM -> outputs 0 immediately, then IF on release with mem_error cleared.
